// File: rtl/sad_accum.sv
// Streaming sum-of-absolute-differences: registers |aIn-bIn| per accepted pair and sums CNT of them.
// Define SAD_SIGNED_EN to treat aIn/bIn as two's-complement; otherwise they are unsigned.
`timescale 1ns/1ps

module sad_accum #(
    parameter int N     = 8,
    parameter int CNT   = 16,
    parameter int ACC_W = N + $clog2(CNT) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     aIn,
    input  logic [N-1:0]     bIn,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out,
    output logic             busy
);

    localparam int CNT_W = (CNT > 1) ? $clog2(CNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CNT - 1);

    typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_HOLD} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [N-1:0]       r_diff;
    logic               r_diff_v;
    logic [ACC_W-1:0]   r_acc;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [N-1:0]       w_absdiff;
    logic [ACC_W-1:0]   w_acc_sum;

`ifdef SAD_SIGNED_EN
    // One extra bit holds any signed difference; its magnitude still fits N bits.
    logic signed [N:0] w_sdiff;
    assign w_sdiff   = $signed({aIn[N-1], aIn}) - $signed({bIn[N-1], bIn});
    assign w_absdiff = w_sdiff[N] ? N'(-w_sdiff) : N'(w_sdiff);
`else
    assign w_absdiff = (aIn >= bIn) ? (aIn - bIn) : (bIn - aIn);
`endif

    assign w_acc_sum = r_acc + ACC_W'(r_diff);

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_ACC;
            r_cnt       <= '0;
            r_diff      <= '0;
            r_diff_v    <= 1'b0;
            r_acc       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    r_diff_v <= in_valid;
                    if (in_valid) r_diff <= w_absdiff;
                    if (r_diff_v) r_acc <= w_acc_sum;
                    if (in_valid) begin
                        if (r_cnt == LAST) begin
                            r_cnt      <= '0;
                            r_state    <= ST_DRAIN;
                            r_in_ready <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The last difference is still in r_diff; fold it in before presenting.
                    r_acc       <= w_acc_sum;
                    r_diff_v    <= 1'b0;
                    r_state     <= ST_HOLD;
                    r_out_valid <= 1'b1;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_acc       <= '0;
                        r_state     <= ST_ACC;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_ACC;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_acc;
    assign busy      = (r_state != ST_ACC) || (r_cnt != '0) || r_diff_v;

endmodule

// File: tb/tb_sad_accum.sv
// Directed bench for sad_accum: three instances (CNT=4, CNT=16, CNT=1), N=8.
`timescale 1ns/1ps

module tb_sad_accum;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [7:0]  a [3];
    logic [7:0]  b [3];
    wire  [2:0]  in_ready;
    wire  [2:0]  out_valid;
    wire  [2:0]  busy;
    wire  [10:0] out0;
    wire  [12:0] out1;
    wire  [8:0]  out2;

    int n_err    = 0;
    int n_checks = 0;

    logic [7:0] pa [16];
    logic [7:0] pb [16];

    always #5 clk = ~clk;

    sad_accum #(.N(8), .CNT(4)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .aIn(a[0]), .bIn(b[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out(out0), .busy(busy[0])
    );

    sad_accum #(.N(8), .CNT(16)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .aIn(a[1]), .bIn(b[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out(out1), .busy(busy[1])
    );

    sad_accum #(.N(8), .CNT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .aIn(a[2]), .bIn(b[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .out(out2), .busy(busy[2])
    );

    function automatic logic [15:0] f_out(int i);
        case (i)
            0:       return 16'(out0);
            1:       return 16'(out1);
            default: return 16'(out2);
        endcase
    endfunction

    task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one pair at a negedge; it is accepted on the following posedge.
    task automatic push(int i, logic [7:0] av, logic [7:0] bv, string tag);
        check({tag, "/in_ready_before_push"}, 16'(in_ready[i]), 16'd1);
        in_valid[i] = 1'b1;
        a[i]        = av;
        b[i]        = bv;
        @(negedge clk);
        in_valid[i] = 1'b0;
        check({tag, "/busy_after_push"}, 16'(busy[i]), 16'd1);
    endtask

    task automatic run_block(int i, int n, int max_gap, int hold,
                             logic [15:0] exp, string tag);
        int g;
        for (int k = 0; k < n; k++) begin
            push(i, pa[k], pb[k], tag);
            if (k < n - 1) begin
                g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                repeat (g) begin
                    @(negedge clk);
                    check({tag, "/busy_in_gap"}, 16'(busy[i]), 16'd1);
                end
            end
        end
        // One cycle after the last accept: draining.
        check({tag, "/drain_in_ready"}, 16'(in_ready[i]), 16'd0);
        check({tag, "/drain_out_valid"}, 16'(out_valid[i]), 16'd0);
        @(negedge clk);
        // Two cycles after the last accept: result presented.
        check({tag, "/hold_out_valid"}, 16'(out_valid[i]), 16'd1);
        check({tag, "/hold_out"}, f_out(i), exp);
        check({tag, "/hold_in_ready"}, 16'(in_ready[i]), 16'd0);
        check({tag, "/hold_busy"}, 16'(busy[i]), 16'd1);
        repeat (hold) begin
            @(negedge clk);
            check({tag, "/stall_out_valid"}, 16'(out_valid[i]), 16'd1);
            check({tag, "/stall_out"}, f_out(i), exp);
        end
        out_ready[i] = 1'b1;
        @(negedge clk);
        out_ready[i] = 1'b0;
        check({tag, "/after_out_valid"}, 16'(out_valid[i]), 16'd0);
        check({tag, "/after_in_ready"}, 16'(in_ready[i]), 16'd1);
        check({tag, "/after_busy"}, 16'(busy[i]), 16'd0);
        check({tag, "/after_acc_cleared"}, f_out(i), 16'd0);
    endtask

    initial begin
        in_valid  = '0;
        out_ready = '0;
        for (int i = 0; i < 3; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("reset/in_ready", 16'(in_ready[i]), 16'd1);
            check("reset/out_valid", 16'(out_valid[i]), 16'd0);
            check("reset/out", f_out(i), 16'd0);
            check("reset/busy", 16'(busy[i]), 16'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // CNT=4, back to back: 7+7+255+0
        pa[0] = 8'd10; pb[0] = 8'd3;
        pa[1] = 8'd3;  pb[1] = 8'd10;
        pa[2] = 8'd255; pb[2] = 8'd0;
        pa[3] = 8'd0;  pb[3] = 8'd0;
        run_block(0, 4, 0, 0, 16'd269, "b2b");

        // Same pairs with input gaps and a 5-cycle output stall
        run_block(0, 4, 3, 5, 16'd269, "gaps");

        // Identical operands sum to zero after the previous result was cleared
        for (int k = 0; k < 4; k++) begin
            pa[k] = 8'd1; pb[k] = 8'd1;
        end
        run_block(0, 4, 1, 1, 16'd0, "zeros");

        // CNT=16 worst case: 16*255
        for (int k = 0; k < 16; k++) begin
            pa[k] = 8'd255; pb[k] = 8'd0;
        end
        run_block(1, 16, 0, 2, 16'd4080, "worst");

        // Reset after two accepts discards the partial block
        push(0, 8'd5, 8'd2, "rst_mid");
        push(0, 8'd5, 8'd2, "rst_mid");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid/in_ready", 16'(in_ready[0]), 16'd1);
        check("rst_mid/out_valid", 16'(out_valid[0]), 16'd0);
        check("rst_mid/busy", 16'(busy[0]), 16'd0);
        check("rst_mid/out", f_out(0), 16'd0);
        for (int k = 0; k < 4; k++) begin
            pa[k] = 8'd5; pb[k] = 8'd2;
        end
        run_block(0, 4, 0, 0, 16'd12, "post_rst");

        // CNT=1: each pair is its own block
        pa[0] = 8'd7; pb[0] = 8'd9;
        run_block(2, 1, 0, 0, 16'd2, "cnt1_a");
        pa[0] = 8'd9; pb[0] = 8'd7;
        run_block(2, 1, 0, 0, 16'd2, "cnt1_b");

        // Operand interpretation differs between builds
        pa[0] = 8'h80; pb[0] = 8'h7F;
`ifdef SAD_SIGNED_EN
        run_block(2, 1, 0, 0, 16'd255, "sign_80_7f");
`else
        run_block(2, 1, 0, 0, 16'd1, "sign_80_7f");
`endif
        pa[0] = 8'hFF; pb[0] = 8'h01;
`ifdef SAD_SIGNED_EN
        run_block(2, 1, 0, 0, 16'd2, "sign_ff_01");
`else
        run_block(2, 1, 0, 0, 16'd254, "sign_ff_01");
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
